// File: rtl/sfr_bank.sv
// sfr_bank: bank of bit-addressable 8051 SFRs with byte/bit access and hardware load.
// Define SFR_BANK_TIMED_ACCESS_EN to build the timed-access (TA) write guard.
module sfr_bank #(
    parameter int unsigned NUM_REGS    = 4,
    parameter logic [7:0]  BASE_ADDR   = 8'hF0,
    parameter logic [7:0]  RESET_VALUE = 8'h00,
    parameter logic [15:0] PROT_MASK   = 16'h0000,
    parameter logic [7:0]  TA_ADDR     = 8'hC7,
    parameter int unsigned TA_WINDOW   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            addr,
    input  logic [7:0]            data_in,
    input  logic                  write_en,
    input  logic                  write_bit_en,
    input  logic                  bit_in,
    input  logic                  rd_en,
    input  logic                  rd_bit_en,
    input  logic [NUM_REGS-1:0]   hw_we,
    input  logic [8*NUM_REGS-1:0] hw_data,
    output logic [7:0]            data_out,
    output logic                  bit_out,
    output logic                  rd_hit,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  ta_open,
    output logic                  prot_err
);

    logic [7:0]          regs_q [NUM_REGS];
    logic [7:0]          regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] sw_wr;
    logic [NUM_REGS-1:0] wr_ok;
    logic [7:0]          data_out_q;
    logic                bit_out_q;
    logic                rd_hit_q;
    logic                rd_sel;
    logic [7:0]          rd_byte;
    logic                rd_bit;
    logic                ta_sel;

`ifdef SFR_BANK_TIMED_ACCESS_EN
    typedef enum logic [1:0] {
        TA_IDLE,
        TA_ARMED,
        TA_OPEN
    } ta_state_e;

    localparam logic [NUM_REGS-1:0] PROT = PROT_MASK[NUM_REGS-1:0];

    ta_state_e  ta_state_q;
    logic [3:0] ta_cnt_q;
    logic       ta_open_q;
    logic       prot_err_q;
    logic       ta_byte_wr;
    logic       prot_drop;
    logic       prot_used;

    assign ta_sel     = addr == TA_ADDR;
    assign ta_byte_wr = write_en & ~write_bit_en & ta_sel;
    assign wr_ok      = sw_wr & (~PROT | {NUM_REGS{ta_open_q}});
    assign prot_drop  = |(sw_wr & PROT & ~{NUM_REGS{ta_open_q}});
    assign prot_used  = |(sw_wr & PROT) & ta_open_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ta_state_q <= TA_IDLE;
            ta_cnt_q   <= 4'd0;
            ta_open_q  <= 1'b0;
            prot_err_q <= 1'b0;
        end else begin
            prot_err_q <= prot_drop;
            unique case (ta_state_q)
                TA_IDLE: begin
                    if (ta_byte_wr && data_in == 8'hAA) begin
                        ta_state_q <= TA_ARMED;
                        ta_cnt_q   <= 4'(TA_WINDOW);
                    end
                end
                TA_ARMED: begin
                    if (ta_byte_wr && data_in == 8'h55) begin
                        ta_state_q <= TA_OPEN;
                        ta_cnt_q   <= 4'(TA_WINDOW);
                        ta_open_q  <= 1'b1;
                    end else if (write_en || ta_cnt_q == 4'd1) begin
                        ta_state_q <= TA_IDLE;
                        ta_cnt_q   <= 4'd0;
                    end else begin
                        ta_cnt_q <= ta_cnt_q - 4'd1;
                    end
                end
                TA_OPEN: begin
                    // one protected write per unlock, or until the budget runs out
                    if (prot_used || ta_cnt_q == 4'd1) begin
                        ta_state_q <= TA_IDLE;
                        ta_cnt_q   <= 4'd0;
                        ta_open_q  <= 1'b0;
                    end else begin
                        ta_cnt_q <= ta_cnt_q - 4'd1;
                    end
                end
                default: begin
                    ta_state_q <= TA_IDLE;
                    ta_cnt_q   <= 4'd0;
                    ta_open_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ta_open  = ta_open_q;
    assign prot_err = prot_err_q;
`else
    assign ta_sel   = 1'b0;
    assign wr_ok    = sw_wr;
    assign ta_open  = 1'b0;
    assign prot_err = 1'b0;
`endif

    always_comb begin
        logic [7:0] ra;
        ra      = 8'h00;
        rd_sel  = 1'b0;
        rd_byte = 8'h00;
        rd_bit  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            ra = BASE_ADDR + 8'(8 * i);
            sw_wr[i] = write_en & ~ta_sel &
                       (write_bit_en ? addr[7:3] == ra[7:3] : addr == ra);
            if (!rd_bit_en && addr == ra) begin
                rd_sel  = 1'b1;
                rd_byte = regs_q[i];
            end
            if (rd_bit_en && addr[7:3] == ra[7:3]) begin
                rd_sel = 1'b1;
                rd_bit = regs_q[i][addr[2:0]];
            end
        end
`ifdef SFR_BANK_TIMED_ACCESS_EN
        if (!rd_bit_en && ta_sel) begin
            rd_sel  = 1'b1;
            rd_byte = {7'b0, ta_open_q};
        end
`endif
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            // an accepted software write wins over the hardware load
            if (wr_ok[i]) begin
                if (write_bit_en) begin
                    regs_d[i][addr[2:0]] = bit_in;
                end else begin
                    regs_d[i] = data_in;
                end
            end else if (hw_we[i]) begin
                regs_d[i] = hw_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
            data_out_q <= 8'h00;
            bit_out_q  <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            if (rd_en) begin
                rd_hit_q <= rd_sel;
                if (!rd_sel) begin
                    data_out_q <= 8'h00;
                    bit_out_q  <= 1'b0;
                end else if (rd_bit_en) begin
                    bit_out_q <= rd_bit;
                end else begin
                    data_out_q <= rd_byte;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_flat[8*i +: 8] = regs_q[i];
        if (8'(BASE_ADDR + 8 * i) == TA_ADDR) begin : g_clash
            $error("sfr_bank: TA_ADDR overlaps a bank register");
        end
    end

    if (BASE_ADDR[2:0] != 3'd0) begin : g_bad_base
        $error("sfr_bank: BASE_ADDR must be 8-byte aligned");
    end
    if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num
        $error("sfr_bank: NUM_REGS out of range");
    end
    if (TA_WINDOW < 1 || TA_WINDOW > 15) begin : g_bad_win
        $error("sfr_bank: TA_WINDOW out of range");
    end
    if ((32'(PROT_MASK) >> NUM_REGS) != 0) begin : g_bad_mask
        $error("sfr_bank: PROT_MASK names registers outside the bank");
    end

    assign data_out = data_out_q;
    assign bit_out  = bit_out_q;
    assign rd_hit   = rd_hit_q;

endmodule

// File: tb/tb_sfr_bank.sv
// tb_sfr_bank: directed stimulus for sfr_bank checked every cycle against a bench model.
// Works with or without SFR_BANK_TIMED_ACCESS_EN defined.
module tb_sfr_bank;

    localparam int          N     = 4;
    localparam logic [7:0]  BASE  = 8'hF0;
    localparam logic [7:0]  TAA   = 8'hC7;
    localparam logic [15:0] PMASK = 16'h0002;
    localparam int          WIN   = 3;
`ifdef SFR_BANK_TIMED_ACCESS_EN
    localparam bit TA_EN = 1'b1;
`else
    localparam bit TA_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    addr = 8'h00;
    logic [7:0]    data_in = 8'h00;
    logic          write_en = 1'b0;
    logic          write_bit_en = 1'b0;
    logic          bit_in = 1'b0;
    logic          rd_en = 1'b0;
    logic          rd_bit_en = 1'b0;
    logic [N-1:0]  hw_we = '0;
    logic [8*N-1:0] hw_data = '0;
    logic [7:0]    data_out;
    logic          bit_out;
    logic          rd_hit;
    logic [8*N-1:0] regs_flat;
    logic          ta_open;
    logic          prot_err;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    sfr_bank #(
        .NUM_REGS(N),
        .BASE_ADDR(BASE),
        .RESET_VALUE(8'h00),
        .PROT_MASK(PMASK),
        .TA_ADDR(TAA),
        .TA_WINDOW(WIN)
    ) dut (
        .clock(clock),
        .reset(reset),
        .addr(addr),
        .data_in(data_in),
        .write_en(write_en),
        .write_bit_en(write_bit_en),
        .bit_in(bit_in),
        .rd_en(rd_en),
        .rd_bit_en(rd_bit_en),
        .hw_we(hw_we),
        .hw_data(hw_data),
        .data_out(data_out),
        .bit_out(bit_out),
        .rd_hit(rd_hit),
        .regs_flat(regs_flat),
        .ta_open(ta_open),
        .prot_err(prot_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model: register contents as a byte array, TA as "cycles left" counters.
    logic [7:0] m_reg [N];
    logic [7:0] m_nxt [N];
    logic [7:0] m_dout;
    logic       m_bout, m_hit, m_perr;
    int         m_arm, m_open, m_t;
    bit         m_tahit, m_used;

    function automatic int byte_idx(input logic [7:0] a);
        for (int i = 0; i < N; i++) if (8'(BASE + 8 * i) == a) return i;
        return -1;
    endfunction

    function automatic int bit_idx(input logic [7:0] a);
        logic [7:0] ra;
        for (int i = 0; i < N; i++) begin
            ra = 8'(BASE + 8 * i);
            if (ra[7:3] == a[7:3]) return i;
        end
        return -1;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) m_reg[i] = 8'h00;
            m_dout = 8'h00; m_bout = 1'b0; m_hit = 1'b0; m_perr = 1'b0;
            m_arm = 0; m_open = 0;
        end else begin
            if (rd_en) begin
                if (!rd_bit_en && TA_EN && addr == TAA) begin
                    m_dout = {7'b0, m_open > 0}; m_hit = 1'b1;
                end else if (!rd_bit_en && byte_idx(addr) >= 0) begin
                    m_dout = m_reg[byte_idx(addr)]; m_hit = 1'b1;
                end else if (rd_bit_en && bit_idx(addr) >= 0) begin
                    m_bout = m_reg[bit_idx(addr)][addr[2:0]]; m_hit = 1'b1;
                end else begin
                    m_dout = 8'h00; m_bout = 1'b0; m_hit = 1'b0;
                end
            end
            m_perr = 1'b0;
            m_used = 1'b0;
            for (int i = 0; i < N; i++)
                m_nxt[i] = hw_we[i] ? hw_data[8*i +: 8] : m_reg[i];
            m_tahit = TA_EN && write_en && addr == TAA;
            m_t = (!write_en || m_tahit) ? -1 :
                  (write_bit_en ? bit_idx(addr) : byte_idx(addr));
            if (m_t >= 0) begin
                if (TA_EN && PMASK[m_t] && m_open == 0) begin
                    m_perr = 1'b1;
                end else begin
                    m_nxt[m_t] = m_reg[m_t];
                    if (write_bit_en) m_nxt[m_t][addr[2:0]] = bit_in;
                    else m_nxt[m_t] = data_in;
                    m_used = TA_EN && PMASK[m_t];
                end
            end
            for (int i = 0; i < N; i++) m_reg[i] = m_nxt[i];
            if (TA_EN) begin
                if (m_open > 0) begin
                    m_open = m_used ? 0 : m_open - 1;
                end else if (m_arm > 0) begin
                    if (write_en) begin
                        m_arm = 0;
                        if (m_tahit && !write_bit_en && data_in == 8'h55) m_open = WIN;
                    end else begin
                        m_arm--;
                    end
                end else if (m_tahit && !write_bit_en && data_in == 8'hAA) begin
                    m_arm = WIN;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("data_out", 32'(data_out), 32'(m_dout));
            chk("bit_out", 32'(bit_out), 32'(m_bout));
            chk("rd_hit", 32'(rd_hit), 32'(m_hit));
            chk("regs_flat", regs_flat, {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
            chk("ta_open", 32'(ta_open), 32'(m_open > 0));
            chk("prot_err", 32'(prot_err), 32'(m_perr));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        write_en = 1'b0; write_bit_en = 1'b0; rd_en = 1'b0;
        rd_bit_en = 1'b0; hw_we = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        idle(); addr = a; data_in = d; write_en = 1'b1;
        step(); idle();
    endtask

    task automatic wrbit(input logic [7:0] a, input logic b);
        idle(); addr = a; bit_in = b; write_en = 1'b1; write_bit_en = 1'b1;
        step(); idle();
    endtask

    task automatic rdb(input logic [7:0] a);
        idle(); addr = a; rd_en = 1'b1;
        step(); idle();
    endtask

    task automatic rdbit(input logic [7:0] a);
        idle(); addr = a; rd_en = 1'b1; rd_bit_en = 1'b1;
        step(); idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #1 reset = 1'b1;
        step(); step();
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_regs", regs_flat, 32'h0);
        chk("rst_hit", 32'(rd_hit), 32'h0);

        rdb(8'hF8);
        chk("rd_f8_data", 32'(data_out), 32'h00);
        chk("rd_f8_hit", 32'(rd_hit), 32'h1);
        rdb(8'h80);
        chk("rd_80_hit", 32'(rd_hit), 32'h0);
        chk("rd_80_data", 32'(data_out), 32'h00);

        wr(8'hF0, 8'h5A);
        wrbit(8'hF7, 1'b1);
        chk("bitwr_reg0", 32'(regs_flat[7:0]), 32'hDA);
        rdbit(8'hF7);
        chk("bitrd_f7", 32'(bit_out), 32'h1);
        rdbit(8'hF2);
        chk("bitrd_f2", 32'(bit_out), 32'h0);

        idle(); hw_we = 4'b0100; hw_data = 32'h0033_0000;
        addr = 8'h00; data_in = 8'hC4; write_en = 1'b1;
        step(); idle();
        chk("prio_sw", 32'(regs_flat[23:16]), 32'hC4);
        hw_we = 4'b0100; step(); idle();
        chk("prio_hw", 32'(regs_flat[23:16]), 32'h33);

        rdb(TAA);
        chk("rd_ta_hit", 32'(rd_hit), 32'(TA_EN));

        wr(TAA, 8'hAA);
        wr(TAA, 8'h55);
        chk("ta_open_up", 32'(ta_open), 32'(TA_EN));
        rdb(TAA);
        chk("rd_ta_data", 32'(data_out), TA_EN ? 32'h1 : 32'h0);
        wr(8'hF8, 8'h77);
        chk("ta_wr_reg1", 32'(regs_flat[15:8]), 32'h77);
        chk("ta_closed", 32'(ta_open), 32'h0);
        wr(8'hF8, 8'h11);
        chk("ta_drop_reg1", 32'(regs_flat[15:8]), TA_EN ? 32'h77 : 32'h11);
        chk("ta_drop_err", 32'(prot_err), 32'(TA_EN));
        step();
        chk("perr_pulse", 32'(prot_err), 32'h0);

        wr(TAA, 8'hAA);
        wr(TAA, 8'h55);
        repeat (4) step();
        wr(8'hF8, 8'h22);
        chk("expiry_reg1", 32'(regs_flat[15:8]), TA_EN ? 32'h77 : 32'h22);

        wr(TAA, 8'hAA);
        wr(8'hF0, 8'h00);
        wr(TAA, 8'h55);
        chk("abort_open", 32'(ta_open), 32'h0);
        wr(8'hF8, 8'h44);
        chk("abort_reg1", 32'(regs_flat[15:8]), TA_EN ? 32'h77 : 32'h44);

        idle(); hw_we = 4'b0010; hw_data = 32'h0000_AB00;
        addr = 8'hF8; data_in = 8'h12; write_en = 1'b1;
        step(); idle();
        chk("drop_hw_reg1", 32'(regs_flat[15:8]), TA_EN ? 32'hAB : 32'h12);
        chk("drop_hw_err", 32'(prot_err), 32'(TA_EN));

        wr(TAA, 8'hAA);
        wr(TAA, 8'h55);
        wr(8'h08, 8'h99);
        chk("open_unprot", 32'(ta_open), 32'(TA_EN));
        wr(8'hF8, 8'h66);
        wr(TAA, 8'hAA);
        wr(TAA, 8'h55);
        wrbit(8'hFF, 1'b1);
        chk("open_bitwr", 32'(regs_flat[15:8]), 32'hE6);

        idle(); addr = 8'hF0; data_in = 8'h3C; write_en = 1'b1; rd_en = 1'b1;
        step(); idle();
        chk("rdw_old", 32'(data_out), 32'h00);
        chk("rdw_new", 32'(regs_flat[7:0]), 32'h3C);
        rdb(8'h08);
        rdb(8'h00);
        rdbit(8'h0B);
        rdbit(8'h40);

        wr(TAA, 8'hAA);
        wr(TAA, 8'h55);
        reset = 1'b1;
        #1;
        chk("rst_mid_open", 32'(ta_open), 32'h0);
        step();
        reset = 1'b0;
        wr(8'hF8, 8'h05);
        chk("rst_mid_reg1", 32'(regs_flat[15:8]), TA_EN ? 32'h00 : 32'h05);
        chk("rst_mid_rest", {regs_flat[31:16], regs_flat[7:0]}, 32'h0);
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
